acc_control: RTL and testbench

Control unit for the 4-bit accumulator datapath. It fetches 8-bit instructions from a 16-word synchronous instruction ROM and holds the accumulator and flags. It drives the ALU's operand and opcode inputs, writes the ALU result back, and handles branching, blocking input and output pulses. It is the issuing side of the ALU interface: the ALU computes, this block decides what it computes and where the result goes.

---
 rtl/acc_control_if.sv | 31 +++
 rtl/acc_control.sv | 158 +++++++++++++++
 tb/tb_acc_control.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_control_if.sv
// Signal bundle between acc_control and its instruction ROM, ALU and I/O ports.
// The master side is the control unit; the slave side is the surrounding datapath.
interface acc_control_if;
  logic        [3:0] imem_addr;
  logic        [7:0] imem_data;
  logic        [3:0] alu_op;
  logic signed [3:0] alu_a;
  logic signed [3:0] alu_b;
  logic signed [3:0] alu_out;
  logic        [3:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic        [3:0] out_data;
  logic              out_valid;
  logic signed [3:0] acc;
  logic              zero;
  logic              neg;
  logic              halted;

  modport master (
    output imem_addr, alu_op, alu_a, alu_b, in_ready,
           out_data, out_valid, acc, zero, neg, halted,
    input  imem_data, alu_out, in_data, in_valid
  );

  modport slave (
    input  imem_addr, alu_op, alu_a, alu_b, in_ready,
           out_data, out_valid, acc, zero, neg, halted,
    output imem_data, alu_out, in_data, in_valid
  );
endinterface

// File: rtl/acc_control.sv
// Control unit for the 4-bit accumulator machine: fetch/exec sequencing, accumulator
// and flags, branch resolution, blocking input port and one-cycle output pulses.
module acc_control #(
  parameter logic [3:0] RESET_PC = 4'd0
) (
  input  logic          clk,
  input  logic          rst,
  acc_control_if.master bus
);

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    IN_WAIT,
    HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_LDI  = 4'd8,
    OP_OUT  = 4'd9,
    OP_JMP  = 4'd10,
    OP_JZ   = 4'd11,
    OP_JN   = 4'd12,
    OP_IN   = 4'd13,
    OP_NOP  = 4'd14,
    OP_HALT = 4'd15
  } opcode_e;

  localparam logic [3:0] ALU_IDLE = 4'd15;

  state_e            state_q, state_d;
  logic        [3:0] pc_q, pc_d;
  logic signed [3:0] acc_q, acc_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic        [3:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  opcode_e           opcode;
  logic        [3:0] imm;
  logic        [3:0] pc_inc;
  logic              acc_we;
  logic signed [3:0] acc_wdata;

  // The ROM word is only meaningful in EXEC; decoding it elsewhere is harmless.
  assign opcode = opcode_e'(bus.imem_data[7:4]);
  assign imm    = bus.imem_data[3:0];
  assign pc_inc = pc_q + 4'd1;

  // NOTE: every signal written here gets a default first, so no path through the
  // case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    acc_we      = 1'b0;
    acc_wdata   = 4'sd0;

    case (state_q)
      FETCH: state_d = EXEC;

      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_NOT, OP_SHL, OP_SHR, OP_LDI: begin
            acc_we    = 1'b1;
            acc_wdata = bus.alu_out;
          end
          OP_OUT: begin
            out_data_d  = acc_q;
            out_valid_d = 1'b1;
          end
          OP_JMP: pc_d = imm;
          OP_JZ:  if (zero_q) pc_d = imm;
          OP_JN:  if (neg_q)  pc_d = imm;
          OP_IN: begin
            pc_d    = pc_q;
            state_d = IN_WAIT;
          end
          OP_NOP: ;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = HALT;
          end
        endcase
      end

      IN_WAIT: begin
        if (bus.in_valid) begin
          acc_we    = 1'b1;
          acc_wdata = $signed(bus.in_data);
          pc_d      = pc_inc;
          state_d   = FETCH;
        end
      end

      HALT: ;
    endcase
  end

  // Flags follow the accumulator write port so branches always see the last write.
  always_comb begin
    acc_d  = acc_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    if (acc_we) begin
      acc_d  = acc_wdata;
      zero_d = (acc_wdata == 4'sd0);
      neg_d  = acc_wdata[3];
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values; blocking here would let later statements see new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      acc_q       <= 4'sd0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      out_data_q  <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.alu_op    = (state_q == EXEC) ? bus.imem_data[7:4] : ALU_IDLE;
  assign bus.alu_a     = $signed(imm);
  assign bus.alu_b     = acc_q;
  assign bus.in_ready  = (state_q == IN_WAIT);
  assign bus.halted    = (state_q == HALT);
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_acc_control.sv
// Bench for acc_control: provides the synchronous ROM and combinational ALU, then
// checks directed vectors, multi-cycle corner sequences and random programs.
module tb_acc_control;

  localparam int         N_PROGS   = 30;
  localparam int         MAX_INSTR = 40;
  localparam logic [3:0] RST_PC    = 4'd0;

  typedef struct {
    logic [63:0] prog;   // words 0..7, word 0 in the top byte
    logic [7:0]  fill;   // words 8..15
    int          edges;  // clock edges after reset release
    logic [3:0]  pc;
    logic [3:0]  acc;
    logic        z;
    logic        n;
    logic        h;
    logic        ov;
    logic [3:0]  od;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rom [16];

  logic [3:0] m_pc, m_acc, m_od;
  logic       m_z, m_n, m_ov;

  acc_control_if bus ();

  acc_control #(.RESET_PC(RST_PC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  always_comb begin
    case (bus.alu_op)
      4'd0:    bus.alu_out = bus.alu_a + bus.alu_b;
      4'd1:    bus.alu_out = bus.alu_a - bus.alu_b;
      4'd2:    bus.alu_out = bus.alu_a & bus.alu_b;
      4'd3:    bus.alu_out = bus.alu_a | bus.alu_b;
      4'd4:    bus.alu_out = bus.alu_a ^ bus.alu_b;
      4'd5:    bus.alu_out = ~bus.alu_b;
      4'd6:    bus.alu_out = bus.alu_b <<< $unsigned(bus.alu_a);
      4'd7:    bus.alu_out = bus.alu_b >>> $unsigned(bus.alu_a);
      4'd8:    bus.alu_out = bus.alu_a;
      default: bus.alu_out = 4'sd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'd0;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_rom(input logic [63:0] prog, input logic [7:0] fill);
    for (int w = 0; w < 16; w++) rom[w] = (w < 8) ? prog[63 - 8*w -: 8] : fill;
  endtask

  task automatic check_reset(input string tag);
    check4({tag, ".pc"},        bus.imem_addr, RST_PC);
    check4({tag, ".acc"},       bus.acc,       4'd0);
    check1({tag, ".zero"},      bus.zero,      1'b1);
    check1({tag, ".neg"},       bus.neg,       1'b0);
    check4({tag, ".out_data"},  bus.out_data,  4'd0);
    check1({tag, ".out_valid"}, bus.out_valid, 1'b0);
    check1({tag, ".in_ready"},  bus.in_ready,  1'b0);
    check1({tag, ".halted"},    bus.halted,    1'b0);
    check4({tag, ".alu_op"},    bus.alu_op,    4'd15);
  endtask

  // Architectural reference: 4-bit values handled as signed integers.
  function automatic int sval(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  function automatic logic [3:0] model_alu(input logic [3:0] op, input logic [3:0] imm,
                                           input logic [3:0] a);
    int i, x, d, r;
    i = sval(imm);
    x = sval(a);
    d = 1 << imm;
    case (op)
      4'd0:    r = i + x;
      4'd1:    r = i - x;
      4'd2:    return imm & a;
      4'd3:    return imm | a;
      4'd4:    return imm ^ a;
      4'd5:    r = -x - 1;
      4'd6:    r = x * d;
      4'd7:    r = (x >= 0) ? x / d : -((-x + d - 1) / d);
      default: r = i;
    endcase
    return 4'(r);
  endfunction

  task automatic set_acc(input logic [3:0] v);
    m_acc = v;
    m_z   = (v == 4'd0);
    m_n   = v[3];
  endtask

  task automatic check_model(input string tag);
    check4({tag, ".pc"},        bus.imem_addr, m_pc);
    check4({tag, ".acc"},       bus.acc,       m_acc);
    check1({tag, ".zero"},      bus.zero,      m_z);
    check1({tag, ".neg"},       bus.neg,       m_n);
    check1({tag, ".out_valid"}, bus.out_valid, m_ov);
    check4({tag, ".out_data"},  bus.out_data,  m_od);
  endtask

  task automatic run_table();
    vec_t vecs [25];
    string tag;
    vecs[0]  = '{64'h850390F0_F0F0F0F0, 8'hF0,  0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{64'h850390F0_F0F0F0F0, 8'hF0,  2, 4'h1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{64'h850390F0_F0F0F0F0, 8'hF0,  4, 4'h2, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{64'h850390F0_F0F0F0F0, 8'hF0,  6, 4'h3, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8};
    vecs[4]  = '{64'h850390F0_F0F0F0F0, 8'hF0,  8, 4'h3, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8};
    vecs[5]  = '{64'h850390F0_F0F0F0F0, 8'hF0, 28, 4'h3, 4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 4'h8};
    vecs[6]  = '{64'h8313B7F0_F0F0F0E0, 8'hF0,  4, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[7]  = '{64'h8313B7F0_F0F0F0E0, 8'hF0,  6, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[8]  = '{64'h8313B7F0_F0F0F0E0, 8'hF0, 10, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[9]  = '{64'h8314B7F0_F0F0F0E0, 8'hF0,  4, 4'h2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[10] = '{64'h8314B7F0_F0F0F0E0, 8'hF0,  6, 4'h3, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[11] = '{64'h8314B7F0_F0F0F0E0, 8'hF0,  8, 4'h3, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[12] = '{64'h83627150_F0F0F0F0, 8'hF0,  2, 4'h1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[13] = '{64'h83627150_F0F0F0F0, 8'hF0,  4, 4'h2, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[14] = '{64'h83627150_F0F0F0F0, 8'hF0,  6, 4'h3, 4'hE, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[15] = '{64'h83627150_F0F0F0F0, 8'hF0,  8, 4'h4, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[16] = '{64'hE0E0E0E0_E0E0E0E0, 8'hE0, 30, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[17] = '{64'hE0E0E0E0_E0E0E0E0, 8'hE0, 32, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[18] = '{64'hE0E0E0E0_E0E0E0E0, 8'hE0, 34, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[19] = '{64'h88C5F0F0_F090F0F0, 8'hF0,  2, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[20] = '{64'h88C5F0F0_F090F0F0, 8'hF0,  4, 4'h5, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[21] = '{64'h88C5F0F0_F090F0F0, 8'hF0,  6, 4'h6, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 4'h8};
    vecs[22] = '{64'h81C4A6F0_F0F090F0, 8'hF0,  4, 4'h2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[23] = '{64'h81C4A6F0_F0F090F0, 8'hF0,  6, 4'h6, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
    vecs[24] = '{64'h81C4A6F0_F0F090F0, 8'hF0,  8, 4'h7, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1};

    foreach (vecs[i]) begin
      load_rom(vecs[i].prog, vecs[i].fill);
      reset_dut();
      repeat (vecs[i].edges) tick();
      tag = $sformatf("vec%0d", i);
      check4({tag, ".pc"},        bus.imem_addr, vecs[i].pc);
      check4({tag, ".acc"},       bus.acc,       vecs[i].acc);
      check1({tag, ".zero"},      bus.zero,      vecs[i].z);
      check1({tag, ".neg"},       bus.neg,       vecs[i].n);
      check1({tag, ".halted"},    bus.halted,    vecs[i].h);
      check1({tag, ".out_valid"}, bus.out_valid, vecs[i].ov);
      check4({tag, ".out_data"},  bus.out_data,  vecs[i].od);
    end
  endtask

  task automatic run_in_seq();
    load_rom(64'hD090F0F0_F0F0F0F0, 8'hF0);
    reset_dut();
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check1($sformatf("in_wait%0d.in_ready", c), bus.in_ready, 1'b1);
      check4($sformatf("in_wait%0d.pc", c),       bus.imem_addr, 4'd0);
      check4($sformatf("in_wait%0d.acc", c),      bus.acc, 4'd0);
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd6;
    check1("in_accept.in_ready_before", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check4("in_accept.acc",      bus.acc,       4'd6);
    check1("in_accept.zero",     bus.zero,      1'b0);
    check1("in_accept.neg",      bus.neg,       1'b0);
    check4("in_accept.pc",       bus.imem_addr, 4'd1);
    check1("in_accept.in_ready", bus.in_ready,  1'b0);
    tick();
    tick();
    check1("in_out.out_valid", bus.out_valid, 1'b1);
    check4("in_out.out_data",  bus.out_data,  4'd6);
    tick();
    check1("in_out.pulse_end", bus.out_valid, 1'b0);
  endtask

  task automatic run_reset_seq();
    load_rom(64'hD090F0F0_F0F0F0F0, 8'hF0);
    reset_dut();
    repeat (3) tick();
    check1("pre_rst_in.in_ready", bus.in_ready, 1'b1);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd5;
    tick();
    check_reset("rst_in_wait");
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    check1("restart_in.in_ready", bus.in_ready,  1'b1);
    check4("restart_in.pc",       bus.imem_addr, RST_PC);
    check4("restart_in.acc",      bus.acc,       4'd0);

    load_rom(64'h850390F0_F0F0F0F0, 8'hF0);
    reset_dut();
    repeat (12) tick();
    check1("pre_rst_halt.halted",   bus.halted,   1'b1);
    check4("pre_rst_halt.out_data", bus.out_data, 4'd8);
    rst = 1'b1;
    tick();
    check_reset("rst_halt");
    rst = 1'b0;
    tick();
    tick();
    check4("restart_halt.acc",    bus.acc,       4'd5);
    check4("restart_halt.pc",     bus.imem_addr, 4'd1);
    check1("restart_halt.halted", bus.halted,    1'b0);
  endtask

  task automatic run_random();
    logic [7:0] word;
    logic [3:0] op, imm, d;
    bit         done;
    int         waits;
    for (int p = 0; p < N_PROGS; p++) begin
      for (int w = 0; w < 16; w++) rom[w] = 8'($urandom);
      reset_dut();
      m_pc = RST_PC; m_acc = 4'd0; m_z = 1'b1; m_n = 1'b0; m_od = 4'd0; m_ov = 1'b0;
      done = 1'b0;
      for (int n = 0; n < MAX_INSTR && !done; n++) begin
        check_model("rnd.fetch");
        check1("rnd.fetch.halted",   bus.halted,   1'b0);
        check1("rnd.fetch.in_ready", bus.in_ready, 1'b0);
        check4("rnd.fetch.alu_op",   bus.alu_op,   4'd15);
        word = rom[m_pc];
        op   = word[7:4];
        imm  = word[3:0];
        bus.in_valid = 1'($urandom);
        bus.in_data  = 4'($urandom);
        tick();
        check4("rnd.exec.alu_op",    bus.alu_op,    op);
        check1("rnd.exec.out_valid", bus.out_valid, 1'b0);
        m_ov = 1'b0;
        bus.in_valid = 1'($urandom);
        case (op)
          4'd9: begin
            m_od = m_acc;
            m_ov = 1'b1;
            m_pc = m_pc + 4'd1;
          end
          4'd10:   m_pc = imm;
          4'd11:   m_pc = m_z ? imm : m_pc + 4'd1;
          4'd12:   m_pc = m_n ? imm : m_pc + 4'd1;
          4'd13, 4'd15: ;
          4'd14:   m_pc = m_pc + 4'd1;
          default: begin
            set_acc(model_alu(op, imm, m_acc));
            m_pc = m_pc + 4'd1;
          end
        endcase
        if (op == 4'd13) begin
          tick();
          waits = $urandom_range(0, 3);
          repeat (waits) begin
            bus.in_valid = 1'b0;
            check1("rnd.in_wait.in_ready", bus.in_ready,  1'b1);
            check4("rnd.in_wait.pc",       bus.imem_addr, m_pc);
            tick();
          end
          d = 4'($urandom);
          bus.in_valid = 1'b1;
          bus.in_data  = d;
          check1("rnd.in_accept.in_ready", bus.in_ready, 1'b1);
          tick();
          bus.in_valid = 1'b0;
          set_acc(d);
          m_pc = m_pc + 4'd1;
        end else if (op == 4'd15) begin
          tick();
          for (int h = 0; h < 3; h++) begin
            check1("rnd.halt.halted",    bus.halted,    1'b1);
            check4("rnd.halt.pc",        bus.imem_addr, m_pc);
            check4("rnd.halt.acc",       bus.acc,       m_acc);
            check1("rnd.halt.out_valid", bus.out_valid, 1'b0);
            check4("rnd.halt.alu_op",    bus.alu_op,    4'd15);
            bus.in_valid = 1'($urandom);
            tick();
          end
          done = 1'b1;
        end else begin
          tick();
        end
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'd0;
    for (int w = 0; w < 16; w++) rom[w] = 8'hF0;
    tick();
    tick();
    check_reset("power_on");
    run_table();
    run_in_seq();
    run_reset_seq();
    run_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
